tile_exerciser: RTL and testbench

- Self-checking stimulus/response engine for a microtile.
- Drives the tile's `ui_in` bus with a generated pattern sequence, waits a programmable settle time, then samples the tile's `uo_out` bus.
- Compacts every sample into a 16-bit MISR signature and flags pass/fail against an expected value.
- Sits on the driving side of the tile's `ui_in`/`uo_out` interface, replacing a simulation-only harness in on-chip self-test.

---
 rtl/tile_exerciser.sv | 119 +++++++++++
 tb/tb_tile_exerciser.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tile_exerciser.sv
// rtl/tile_exerciser.sv - microtile stimulus/response engine with 16-bit MISR signature check
// Optional LFSR pattern generator selected by TILE_EXERCISER_LFSR_EN (counter generator otherwise).
module tile_exerciser #(
    parameter int SETTLE       = 2,
    parameter int NUM_PATTERNS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  seed,
    input  logic [15:0] expected,
    output logic [7:0]  tile_ui,
    input  logic [7:0]  tile_uo,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [8:0] LAST_COUNT  = 9'(NUM_PATTERNS - 1);

    state_t      state, state_nxt;
    logic [7:0]  ui_q, ui_nxt;
    logic [15:0] misr_q, misr_nxt;
    logic [8:0]  count_q, count_nxt;
    logic [3:0]  settle_q, settle_nxt;
    logic        fb;

`ifdef TILE_EXERCISER_LFSR_EN
    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    function automatic logic [7:0] first_pattern(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [7:0] next_pattern(input logic [7:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction
`else
    function automatic logic [7:0] first_pattern(input logic [7:0] s);
        return s;
    endfunction

    function automatic logic [7:0] next_pattern(input logic [7:0] p);
        return p + 8'd1;
    endfunction
`endif

    assign fb = misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10];

    always_comb begin
        state_nxt  = state;
        ui_nxt     = ui_q;
        misr_nxt   = misr_q;
        count_nxt  = count_q;
        settle_nxt = settle_q;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ui_nxt     = first_pattern(seed);
                    misr_nxt   = 16'h0000;
                    count_nxt  = 9'd0;
                    settle_nxt = SETTLE_LOAD;
                    state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    settle_nxt = settle_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                // tile_uo is combinational from tile_ui, captured at the closing edge of this cycle.
                misr_nxt  = {misr_q[14:0], fb} ^ {8'h00, tile_uo};
                count_nxt = count_q + 9'd1;
                if (count_q == LAST_COUNT) begin
                    state_nxt = ST_DONE;
                end else begin
                    ui_nxt     = next_pattern(ui_q);
                    settle_nxt = SETTLE_LOAD;
                    state_nxt  = ST_SETTLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ui_q     <= 8'h00;
            misr_q   <= 16'h0000;
            count_q  <= 9'd0;
            settle_q <= 4'd0;
        end else begin
            state    <= state_nxt;
            ui_q     <= ui_nxt;
            misr_q   <= misr_nxt;
            count_q  <= count_nxt;
            settle_q <= settle_nxt;
        end
    end

    assign tile_ui   = ui_q;
    assign signature = misr_q;
    assign busy      = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done      = (state == ST_DONE);
    assign pass      = done && (misr_q == expected);

endmodule

// File: tb/tb_tile_exerciser.sv
// tb/tb_tile_exerciser.sv - directed self-checking bench for tile_exerciser in loopback
module tb_tile_exerciser;

`ifdef TILE_EXERCISER_LFSR_EN
    localparam int NP = 5;
`else
    localparam int NP = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic [15:0] expected = 16'h0000;
    logic [7:0]  tile_ui;
    logic [7:0]  tile_uo;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign tile_uo = tile_ui;

    tile_exerciser #(.SETTLE(2), .NUM_PATTERNS(NP)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .seed(seed),
        .expected(expected),
        .tile_ui(tile_ui),
        .tile_uo(tile_uo),
        .busy(busy),
        .done(done),
        .pass(pass),
        .signature(signature)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after the edge that accepts start.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        total++; if (tile_ui !== 8'h00) begin bad++; $display("FAIL reset_tile_ui got=%h want=00", tile_ui); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
        total++; if (signature !== 16'h0000) begin bad++; $display("FAIL reset_sig got=%h want=0000", signature); end
    endtask

    task automatic test_counter_run();
        logic [7:0] want_ui;
        seed = 8'h00;
        expected = 16'h0003;
        pulse_start();
        for (int k = 0; k <= 12; k++) begin
            want_ui = (k < 12) ? 8'(k / 3) : 8'h03;
            total++; if (tile_ui !== want_ui) begin bad++; $display("FAIL run_tile_ui k=%0d got=%h want=%h", k, tile_ui, want_ui); end
            total++; if (done !== (k == 12)) begin bad++; $display("FAIL run_done k=%0d got=%b want=%b", k, done, k == 12); end
            total++; if (busy !== (k < 12)) begin bad++; $display("FAIL run_busy k=%0d got=%b want=%b", k, busy, k < 12); end
            if (k < 12) step();
        end
        total++; if (signature !== 16'h0003) begin bad++; $display("FAIL run_sig got=%h want=0003", signature); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL run_pass got=%b want=1", pass); end
        step();
        step();
        total++; if (done !== 1'b1 || signature !== 16'h0003 || tile_ui !== 8'h03) begin
            bad++; $display("FAIL done_hold done=%b sig=%h ui=%h want 1/0003/03", done, signature, tile_ui);
        end
    endtask

    task automatic test_mismatch();
        expected = 16'h0004;
        pulse_start();
        total++; if (done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL restart_flags done=%b busy=%b want 0/1", done, busy);
        end
        for (int k = 1; k <= 12; k++) step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mismatch_done got=%b want=1", done); end
        total++; if (signature !== 16'h0003) begin bad++; $display("FAIL mismatch_sig got=%h want=0003", signature); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL mismatch_pass got=%b want=0", pass); end
        expected = 16'h0003;
        #1;
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL pass_follows_expected got=%b want=1", pass); end
    endtask

    task automatic test_start_while_busy();
        seed = 8'h00;
        expected = 16'h0003;
        pulse_start();
        for (int k = 0; k <= 12; k++) begin
            total++; if (done !== (k == 12)) begin bad++; $display("FAIL busy_start_done k=%0d got=%b want=%b", k, done, k == 12); end
            if (k == 4) start = 1'b1;
            if (k < 12) step();
            start = 1'b0;
        end
        total++; if (signature !== 16'h0003) begin bad++; $display("FAIL busy_start_sig got=%h want=0003", signature); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        for (int k = 1; k <= 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (tile_ui !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== 16'h0000) begin
            bad++; $display("FAIL midrun_reset ui=%h busy=%b done=%b pass=%b sig=%h want all 0", tile_ui, busy, done, pass, signature);
        end
        step();
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midrun_idle busy=%b done=%b want 0/0", busy, done);
        end
        test_counter_run();
    endtask

    task automatic test_lfsr();
        logic [7:0] tab [5];
        tab[0] = 8'h01; tab[1] = 8'h02; tab[2] = 8'h04; tab[3] = 8'h08; tab[4] = 8'h11;
        seed = 8'h00;
        expected = 16'h0011;
        pulse_start();
        for (int k = 0; k <= 15; k++) begin
            if (k < 15 && (k % 3) == 0) begin
                total++; if (tile_ui !== tab[k / 3]) begin bad++; $display("FAIL lfsr_ui k=%0d got=%h want=%h", k, tile_ui, tab[k / 3]); end
            end
            total++; if (done !== (k == 15)) begin bad++; $display("FAIL lfsr_done k=%0d got=%b want=%b", k, done, k == 15); end
            if (k < 15) step();
        end
        total++; if (signature !== 16'h0011) begin bad++; $display("FAIL lfsr_sig got=%h want=0011", signature); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL lfsr_pass got=%b want=1", pass); end
    endtask

    initial begin
        test_reset();
`ifdef TILE_EXERCISER_LFSR_EN
        test_lfsr();
`else
        test_counter_run();
        test_mismatch();
        test_start_while_busy();
        test_reset_mid_run();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
